// File: rtl/time_digits_seq.sv
// Sequential time-field to BCD digit converter with one double-dabble engine shared by all channels.
// Published digits and overflow flags change only when a whole request has finished converting.
module time_digits_seq #(
    parameter int         CH       = 3,
    parameter int         FW       = 6,
    parameter int         DIG      = 2,
    parameter int         SEP_EN   = 1,
    parameter logic [3:0] SEP_CODE = 4'hA,
    localparam int        NDIG     = CH*DIG + SEP_EN*(CH-1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CH*FW-1:0]   fields,
    output logic [NDIG*4-1:0]  digits,
    output logic               out_valid,
    output logic [CH-1:0]      ovf,
    output logic               busy
);

    localparam int MAXV = 10**DIG - 1;
    // ceil(FW*log10(2)) + 1 nibbles, so the shift never drops a carry
    localparam int XN   = (FW*30103 + 99999)/100000 + 1;
    localparam int SN   = (XN > DIG) ? XN : DIG;
    localparam int SW   = SN*4;
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int BW   = $clog2(FW+1);
    localparam int CMPW = FW + 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_STORE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic [CH*FW-1:0]            fld_q, fld_d;
    logic [CW-1:0]               ch_q, ch_d;
    logic [BW-1:0]               bitcnt_q, bitcnt_d;
    logic [SW-1:0]               scr_q, scr_d;
    logic [CH-1:0][DIG*4-1:0]    pend_q, pend_d;
    logic [CH-1:0]               pend_ovf_q, pend_ovf_d;
    logic [CH-1:0][DIG*4-1:0]    dig_q, dig_d;
    logic [CH-1:0]               ovf_q, ovf_d;
    logic                        out_valid_q, out_valid_d;

    logic [FW-1:0]               cur_fld;
    logic                        cur_ovf;
    logic                        cur_bit;
    logic [SW-1:0]               adj;

    function automatic logic [SW-1:0] dd_adj(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = s;
        for (int i = 0; i < SN; i++) begin
            if (s[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        cur_fld = fld_q[(CH-1-int'(ch_q))*FW +: FW];
        cur_ovf = {{32{1'b0}}, cur_fld} > CMPW'(MAXV);
        cur_bit = cur_fld[FW-1-int'(bitcnt_q)];
        adj     = dd_adj(scr_q);
    end

    always_comb begin
        state_d     = state_q;
        fld_d       = fld_q;
        ch_d        = ch_q;
        bitcnt_d    = bitcnt_q;
        scr_d       = scr_q;
        pend_d      = pend_q;
        pend_ovf_d  = pend_ovf_q;
        dig_d       = dig_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    fld_d    = fields;
                    ch_d     = '0;
                    bitcnt_d = '0;
                    scr_d    = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scr_d    = (adj << 1) | SW'(cur_bit);
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == BW'(FW-1))
                    state_d = S_STORE;
            end
            S_STORE: begin
                // Overflow comes from the binary value; the scratch may hold more digits than DIG
                pend_d[ch_q]               = cur_ovf ? {DIG{4'h9}} : scr_q[DIG*4-1:0];
                pend_ovf_d[CH-1-int'(ch_q)] = cur_ovf;
                if (ch_q == CW'(CH-1)) begin
                    state_d = S_DONE;
                end else begin
                    ch_d     = ch_q + 1'b1;
                    scr_d    = '0;
                    bitcnt_d = '0;
                    state_d  = S_SHIFT;
                end
            end
            default: begin
                dig_d       = pend_q;
                ovf_d       = pend_ovf_q;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fld_q       <= '0;
            ch_q        <= '0;
            bitcnt_q    <= '0;
            scr_q       <= '0;
            pend_q      <= '0;
            pend_ovf_q  <= '0;
            dig_q       <= '0;
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fld_q       <= fld_d;
            ch_q        <= ch_d;
            bitcnt_q    <= bitcnt_d;
            scr_q       <= scr_d;
            pend_q      <= pend_d;
            pend_ovf_q  <= pend_ovf_d;
            dig_q       <= dig_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Separator slots are constants, so only registered digits ever reach the display
    for (genvar c = 0; c < CH; c++) begin : g_slot
        assign digits[(NDIG - c*(DIG+SEP_EN) - DIG)*4 +: DIG*4] = dig_q[c];
        if (SEP_EN != 0 && c < CH-1) begin : g_sep
            assign digits[(NDIG-1-(c*(DIG+SEP_EN)+DIG))*4 +: 4] = SEP_CODE;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = !in_ready;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule
